// File: rtl/ps2_host_tx_module.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, then clocks out
// start/data/parity/stop on the device clock and checks the device ACK.
module ps2_host_tx_module #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int CNT_W          = 20
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       PS2_CLK_Pin_In,
    input  logic       PS2_DAT_Pin_In,
    input  logic       Tx_En,
    input  logic [7:0] Tx_Data,
    output logic       PS2_CLK_OE,
    output logic       PS2_DAT_OE,
    output logic       Tx_Busy,
    output logic       Tx_Done_Sig,
    output logic       Tx_Err_Sig
);

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, SEND, WAIT_IDLE, ERROR
    } state_t;

    // INHIBIT hands over to RTS one cycle early so the clock line is held
    // low for exactly INHIBIT_CYCLES cycles in total.
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, next_state;
    logic [2:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [9:0]       frame;
    logic             fall, lines_idle, cnt_clr;
    logic             nxt_clk_oe, nxt_dat_oe, nxt_busy, nxt_done, nxt_err;

    assign fall       = clk_sync[2] & ~clk_sync[1];
    assign lines_idle = clk_sync[1] & dat_sync[1];
    assign cnt_clr    = (next_state != state) &&
                        (next_state == INHIBIT || next_state == SEND);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= IDLE;
            clk_sync    <= 3'b111;
            dat_sync    <= 2'b11;
            cnt         <= '0;
            bit_cnt     <= '0;
            frame       <= '0;
            PS2_CLK_OE  <= 1'b0;
            PS2_DAT_OE  <= 1'b0;
            Tx_Busy     <= 1'b0;
            Tx_Done_Sig <= 1'b0;
            Tx_Err_Sig  <= 1'b0;
        end else begin
            state       <= next_state;
            clk_sync    <= {clk_sync[1:0], PS2_CLK_Pin_In};
            dat_sync    <= {dat_sync[0], PS2_DAT_Pin_In};
            PS2_CLK_OE  <= nxt_clk_oe;
            PS2_DAT_OE  <= nxt_dat_oe;
            Tx_Busy     <= nxt_busy;
            Tx_Done_Sig <= nxt_done;
            Tx_Err_Sig  <= nxt_err;
            if (cnt_clr)
                cnt <= '0;
            else if (state != IDLE)
                cnt <= cnt + 1'b1;
            if (state == RTS)
                bit_cnt <= '0;
            else if (state == SEND && fall)
                bit_cnt <= bit_cnt + 1'b1;
            // Frame order matches the edge order: D0..D7, odd parity, stop.
            if (state == IDLE && Tx_En)
                frame <= {1'b1, ~^Tx_Data, Tx_Data};
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (Tx_En) next_state = INHIBIT;
            INHIBIT:   if (cnt == INH_LAST) next_state = RTS;
            RTS:       next_state = SEND;
            SEND: begin
                if (cnt == TO_LAST)
                    next_state = ERROR;
                else if (fall && bit_cnt == 4'd10)
                    next_state = dat_sync[1] ? ERROR : WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (cnt == TO_LAST)
                    next_state = ERROR;
                else if (lines_idle)
                    next_state = IDLE;
            end
            ERROR:     next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        nxt_clk_oe = (next_state == INHIBIT) || (next_state == RTS);
        nxt_busy   = (next_state == INHIBIT) || (next_state == RTS) ||
                     (next_state == SEND)    || (next_state == WAIT_IDLE);
        nxt_done   = (state == WAIT_IDLE) && (next_state == IDLE);
        nxt_err    = (next_state == ERROR);
        nxt_dat_oe = 1'b0;
        case (next_state)
            RTS:  nxt_dat_oe = 1'b1;
            SEND: begin
                if (state == RTS)
                    nxt_dat_oe = 1'b1;
                else if (fall && bit_cnt < 4'd10)
                    nxt_dat_oe = ~frame[bit_cnt];
                else
                    nxt_dat_oe = PS2_DAT_OE;
            end
            default: nxt_dat_oe = 1'b0;
        endcase
    end

endmodule
